// File: rtl/config_loader.sv
// config_loader: clears a config chain, shifts bytes into it LSB first and
// returns the chain's previous contents as bytes.
// Ports: clock/nreset; start; word_data/word_valid/word_ready byte stream;
// config_data/config_enable/config_nreset/config_return chain pins;
// rb_data/rb_valid readback; busy/done status.
module config_loader #(
  parameter int CHAIN_LENGTH = 1024,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] word_data,
  input  logic       word_valid,
  output logic       word_ready,
  output logic       config_data,
  output logic       config_enable,
  output logic       config_nreset,
  input  logic       config_return,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LENGTH - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    clr_q, clr_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [7:0]    buf_q, buf_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [7:0]    rbs_q, rbs_d;
  logic [2:0]    rbc_q, rbc_d;

  logic       ready_q, ready_d;
  logic       cdata_q, cdata_d;
  logic       cen_q, cen_d;
  logic       cnres_q, cnres_d;
  logic [7:0] rbd_q, rbd_d;
  logic       rbv_q, rbv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       shift;
  logic       accept;
  logic       last;
  logic [7:0] rb_word;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    rbs_d   = rbs_q;
    rbc_d   = rbc_q;
    rbv_d   = 1'b0;
    rbd_d   = rbd_q;
    shift   = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    rb_word = rbs_q | ({7'd0, config_return} << rbc_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          clr_d   = '0;
          bit_d   = '0;
          buf_d   = '0;
          bcnt_d  = '0;
          rbs_d   = '0;
          rbc_d   = '0;
        end
      end
      CLEAR: begin
        if (clr_q == CLR_LAST) begin
          state_d = SHIFT;
        end else begin
          clr_d = clr_q + 8'd1;
        end
      end
      SHIFT: begin
        shift  = (bcnt_q != 4'd0);
        accept = word_valid && ready_q;
        last   = shift && (bit_q == LAST_BIT);
        if (shift) begin
          buf_d  = {1'b0, buf_q[7:1]};
          bcnt_d = bcnt_q - 4'd1;
          bit_d  = bit_q + CW'(1);
          rbs_d  = rb_word;
          rbc_d  = rbc_q + 3'd1;
          // a full byte or the final (possibly partial) byte is
          // registered here, so the last one shows up in FINISH
          if (rbc_q == 3'd7 || last) begin
            rbv_d = 1'b1;
            rbd_d = rb_word;
            rbs_d = '0;
            rbc_d = '0;
          end
        end
        // a new word replaces the buffer as its last bit goes out
        if (accept) begin
          buf_d  = word_data;
          bcnt_d = 4'd8;
        end
        if (last) begin
          state_d = FINISH;
          buf_d   = '0;
          bcnt_d  = '0;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // outputs are registered from next state
    busy_d  = (state_d != IDLE);
    cnres_d = (state_d != CLEAR);
    cen_d   = (state_d == SHIFT) && (bcnt_d != 4'd0);
    cdata_d = cen_d && buf_d[0];
    ready_d = (state_d == SHIFT) && (bcnt_d <= 4'd1);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      clr_q   <= '0;
      bit_q   <= '0;
      buf_q   <= '0;
      bcnt_q  <= '0;
      rbs_q   <= '0;
      rbc_q   <= '0;
      ready_q <= 1'b0;
      cdata_q <= 1'b0;
      cen_q   <= 1'b0;
      cnres_q <= 1'b0;
      rbd_q   <= '0;
      rbv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      bit_q   <= bit_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      rbs_q   <= rbs_d;
      rbc_q   <= rbc_d;
      ready_q <= ready_d;
      cdata_q <= cdata_d;
      cen_q   <= cen_d;
      cnres_q <= cnres_d;
      rbd_q   <= rbd_d;
      rbv_q   <= rbv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign word_ready    = ready_q;
  assign config_data   = cdata_q;
  assign config_enable = cen_q;
  assign config_nreset = cnres_q;
  assign rb_data       = rbd_q;
  assign rb_valid      = rbv_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: 16-bit and 12-bit chain instances, table loads,
// hand sequences for start/reset corners, random loads vs a byte model.
module tb_config_loader;

  logic       clock = 1'b0;
  logic       nreset = 1'b1;
  logic       start = 1'b0;
  logic       word_valid = 1'b0;
  logic [7:0] word_data = 8'd0;
  logic       sel = 1'b0;
  logic       ld_ch = 1'b0;
  logic [15:0] pre = 16'd0;

  logic s16, s12;
  logic wr16, cd16, ce16, cn16, rbv16, bz16, dn16;
  logic wr12, cd12, ce12, cn12, rbv12, bz12, dn12;
  logic [7:0] rbd16, rbd12;
  logic [15:0] ch16 = 16'd0;
  logic [11:0] ch12 = 12'd0;

  assign s16 = start & ~sel;
  assign s12 = start & sel;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ld_ch) ch16 <= pre;
    else if (ce16) ch16 <= {cd16, ch16[15:1]};
  end

  always @(posedge clock) begin
    if (ld_ch) ch12 <= pre[11:0];
    else if (ce12) ch12 <= {cd12, ch12[11:1]};
  end

  config_loader #(.CHAIN_LENGTH(16), .CLEAR_CYCLES(4)) dut16 (
    .clock(clock), .nreset(nreset), .start(s16),
    .word_data(word_data), .word_valid(word_valid),
    .word_ready(wr16), .config_data(cd16),
    .config_enable(ce16), .config_nreset(cn16),
    .config_return(ch16[0]), .rb_data(rbd16),
    .rb_valid(rbv16), .busy(bz16), .done(dn16)
  );

  config_loader #(.CHAIN_LENGTH(12), .CLEAR_CYCLES(4)) dut12 (
    .clock(clock), .nreset(nreset), .start(s12),
    .word_data(word_data), .word_valid(word_valid),
    .word_ready(wr12), .config_data(cd12),
    .config_enable(ce12), .config_nreset(cn12),
    .config_return(ch12[0]), .rb_data(rbd12),
    .rb_valid(rbv12), .busy(bz12), .done(dn12)
  );

  logic m_ready, m_data, m_en, m_nrst, m_rbv, m_busy, m_done;
  logic [7:0] m_rbd;
  assign m_ready = sel ? wr12 : wr16;
  assign m_data  = sel ? cd12 : cd16;
  assign m_en    = sel ? ce12 : ce16;
  assign m_nrst  = sel ? cn12 : cn16;
  assign m_rbv   = sel ? rbv12 : rbv16;
  assign m_rbd   = sel ? rbd12 : rbd16;
  assign m_busy  = sel ? bz12 : bz16;
  assign m_done  = sel ? dn12 : dn16;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // observations of one load
  int         o_clr, o_nbits, o_bub, o_done, o_bad;
  logic [15:0] o_bits;
  logic [7:0] o_rb[$];
  bit         o_rbdone, o_busy_after, o_to;

  task automatic run_load(input logic s, input logic [7:0] w0,
                          input logic [7:0] w1, input int gap,
                          input bit mid, input bit rnd,
                          input logic [15:0] p);
    logic [7:0] w[2];
    int wi, g, cyc, fen, len;
    bit fin, saw_done, mid_done;
    w[0] = w0; w[1] = w1;
    wi = 0; g = 0; cyc = 0; fen = -1; len = -1;
    fin = 0; saw_done = 0; mid_done = 0;
    o_clr = 0; o_nbits = 0; o_bub = 0; o_done = 0; o_bad = 0;
    o_bits = '0; o_rb.delete();
    o_rbdone = 0; o_busy_after = 1; o_to = 0;
    @(negedge clock);
    sel = s; pre = p; ld_ch = 1'b1;
    @(negedge clock);
    ld_ch = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      start = 1'b0;
      if (saw_done) begin
        o_busy_after = m_busy;
        if (m_done) o_done++;
        fin = 1;
        word_valid = 1'b0;
      end else begin
        if (m_busy && !m_nrst) o_clr++;
        if (!m_en && m_data) o_bad++;
        if (m_en) begin
          if (o_nbits < 16) o_bits[o_nbits[3:0]] = m_data;
          o_nbits++;
          if (fen < 0) fen = cyc;
          len = cyc;
          if (mid && !mid_done && o_nbits == 3) begin
            start = 1'b1;
            mid_done = 1;
          end
        end
        if (m_rbv) begin
          o_rb.push_back(m_rbd);
          if (m_done) o_rbdone = 1;
        end
        if (m_done) begin
          o_done++;
          saw_done = 1;
        end
        if (wi < 2) begin
          if (rnd) word_valid = 1'($urandom_range(0, 1));
          else word_valid = (g == 0);
          word_data = word_valid ? w[wi] : 8'($urandom);
          if (word_valid && m_ready) begin
            wi++;
            g = gap;
          end else if (!word_valid && m_ready && g > 0) begin
            g--;
          end
        end else begin
          word_valid = 1'b0;
        end
      end
      @(negedge clock);
      cyc++;
    end
    if (!fin) o_to = 1;
    if (fen >= 0) o_bub = (len - fen + 1) - o_nbits;
    word_valid = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          gap;
    bit          mid;
    logic [15:0] pre;
    int          nbits;
    logic [15:0] bits;
    int          bub;
    logic [7:0]  rb0;
    logic [7:0]  rb1;
  } vec_t;

  vec_t vt[5];

  task automatic check_common(input string t, input int nb,
                              input logic [15:0] bits,
                              input logic [7:0] rb0,
                              input logic [7:0] rb1);
    logic [15:0] ch;
    ch = sel ? {4'd0, ch12} : ch16;
    chk({t, "_timeout"}, 32'(o_to), 32'd0);
    chk({t, "_nbits"}, 32'(o_nbits), 32'(nb));
    chk({t, "_bits"}, 32'(o_bits), 32'(bits));
    chk({t, "_nrb"}, 32'(o_rb.size()), 32'd2);
    if (o_rb.size() == 2) begin
      chk({t, "_rb0"}, 32'(o_rb[0]), 32'(rb0));
      chk({t, "_rb1"}, 32'(o_rb[1]), 32'(rb1));
    end
    chk({t, "_rb_done"}, 32'(o_rbdone), 32'd1);
    chk({t, "_done"}, 32'(o_done), 32'd1);
    chk({t, "_busy_after"}, 32'(o_busy_after), 32'd0);
    chk({t, "_chain"}, 32'(ch), 32'(bits));
    chk({t, "_idle_data"}, 32'(o_bad), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n, c, L;
    logic [7:0] rw0, rw1;
    logic [15:0] rp, mask, eb;
    logic [7:0] erb1;
    string t;

    vt[0] = '{s:1'b0, w0:8'hA5, w1:8'h3C, gap:0, mid:0,
              pre:16'hBEEF, nbits:16, bits:16'h3CA5, bub:0,
              rb0:8'hEF, rb1:8'hBE};
    vt[1] = '{s:1'b0, w0:8'hA5, w1:8'h3C, gap:3, mid:0,
              pre:16'hBEEF, nbits:16, bits:16'h3CA5, bub:3,
              rb0:8'hEF, rb1:8'hBE};
    vt[2] = '{s:1'b1, w0:8'hFF, w1:8'hFF, gap:0, mid:0,
              pre:16'h0FFF, nbits:12, bits:16'h0FFF, bub:0,
              rb0:8'hFF, rb1:8'h0F};
    vt[3] = '{s:1'b1, w0:8'h12, w1:8'h34, gap:0, mid:0,
              pre:16'h0ABC, nbits:12, bits:16'h0412, bub:0,
              rb0:8'hBC, rb1:8'h0A};
    vt[4] = '{s:1'b0, w0:8'hA5, w1:8'h3C, gap:0, mid:1,
              pre:16'hBEEF, nbits:16, bits:16'h3CA5, bub:0,
              rb0:8'hEF, rb1:8'hBE};

    // reset values
    #2 nreset = 1'b0;
    #2;
    chk("rst_nrst", 32'(m_nrst), 32'd0);
    chk("rst_en", 32'(m_en), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_rbv", 32'(m_rbv), 32'd0);
    chk("rst_rbd", 32'(m_rbd), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    chk("rst_release_nrst", 32'(m_nrst), 32'd1);
    chk("rst_release_busy", 32'(m_busy), 32'd0);

    foreach (vt[i]) begin
      t = $sformatf("v%0d", i);
      run_load(vt[i].s, vt[i].w0, vt[i].w1, vt[i].gap,
               vt[i].mid, 1'b0, vt[i].pre);
      chk({t, "_clear"}, 32'(o_clr), 32'd4);
      chk({t, "_bubbles"}, 32'(o_bub), 32'(vt[i].bub));
      check_common(t, vt[i].nbits, vt[i].bits,
                   vt[i].rb0, vt[i].rb1);
    end

    // reset after the 5th shift aborts the load
    @(negedge clock);
    sel = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    word_valid = 1'b1;
    word_data = 8'hA5;
    n = 0; c = 0;
    while (n < 5 && c < 100) begin
      if (m_en) n++;
      @(negedge clock);
      c++;
    end
    chk("midrst_reach", 32'(n), 32'd5);
    nreset = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("midrst_nrst", 32'(m_nrst), 32'd0);
    chk("midrst_en", 32'(m_en), 32'd0);
    chk("midrst_busy", 32'(m_busy), 32'd0);
    chk("midrst_ready", 32'(m_ready), 32'd0);
    chk("midrst_rbd", 32'(m_rbd), 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (m_done || m_busy) n++;
    end
    chk("midrst_no_done", 32'(n), 32'd0);
    chk("midrst_nrst_back", 32'(m_nrst), 32'd1);
    run_load(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 16'hBEEF);
    chk("reload_clear", 32'(o_clr), 32'd4);
    check_common("reload", 16, 16'h3CA5, 8'hEF, 8'hBE);

    // random loads against a byte-level model
    for (int k = 0; k < 12; k++) begin
      logic rs;
      rs  = 1'($urandom_range(0, 1));
      rw0 = 8'($urandom);
      rw1 = 8'($urandom);
      rp  = 16'($urandom);
      L = rs ? 12 : 16;
      mask = 16'((32'd1 << L) - 1);
      eb = {rw1, rw0} & mask;
      erb1 = 8'((rp & mask) >> 8);
      run_load(rs, rw0, rw1, 0, 1'b0, 1'b1, rp);
      t = $sformatf("rnd%0d", k);
      check_common(t, L, eb, rp[7:0], erb1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_LENGTH, default 1024: number of configuration bits in the target chain, range 1 to 65535.
REQ-002 Parameter CLEAR_CYCLES, default 4: number of cycles config_nreset is held low before shifting, range 1 to 255.
REQ-003 The ports SHALL be as follows; the block has one clock, and its reset is asynchronous and active-low:
- clock  in  1  single clock, rising edge
- nreset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- word_data  in  8  configuration word, LSB shifted first
- word_valid  in  1  word_data valid
- word_ready  out  1  loader accepts word_data this cycle
- config_data  out  1  bit to the chain's config_in
- config_enable  out  1  chain shift enable
- config_nreset  out  1  chain clear, active-low
- config_return  in  1  chain's config_out (readback bit)
- rb_data  out  8  readback word, first returned bit in bit 0
- rb_valid  out  1  one-cycle strobe; rb_data valid, no backpressure
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the last bit has shifted

Function
REQ-004 The FSM SHALL have four states: IDLE, CLEAR, SHIFT and FINISH.
REQ-005 IDLE with start=1 SHALL move to CLEAR on the next edge; start in any other state SHALL be ignored.
REQ-006 CLEAR SHALL drive config_nreset=0 and config_enable=0 for exactly CLEAR_CYCLES cycles, then move to SHIFT.
REQ-007 word_ready SHALL be 1 in SHIFT when the 8-bit word buffer is empty, or when the buffer holds its last unshifted bit; it SHALL be 0 in every other state.
REQ-008 A word SHALL be accepted on any cycle with word_valid=1 and word_ready=1.
REQ-009 In SHIFT, on each cycle with a buffered bit available, config_enable SHALL be 1, config_data SHALL equal the next buffered bit (LSB first), and the bit counter SHALL increment.
REQ-010 In SHIFT, when no buffered bit is available, config_enable SHALL be 0 and config_data SHALL be 0.
REQ-011 Back-to-back words SHALL shift with no bubble cycles when word_valid is held high.
REQ-012 When the bit counter reaches CHAIN_LENGTH, the FSM SHALL enter FINISH, and any unshifted bits remaining in the last word SHALL be discarded.
REQ-013 FINISH SHALL last one cycle, assert done=1, flush any partial readback word, and return to IDLE.
REQ-014 On every cycle with config_enable=1, config_return SHALL be sampled into the readback shifter at the next free bit position, starting at bit 0.
REQ-015 After every 8th sampled bit, rb_valid SHALL pulse for one cycle with the completed word.
REQ-016 When CHAIN_LENGTH is not a multiple of 8, the final rb word SHALL be emitted in FINISH with its unused high bits set to 0.
REQ-017 A rb_valid pulse for a full word and the flush of a partial word SHALL never coincide; a full 8th bit on the last shift emits in FINISH only.
REQ-018 busy SHALL be 1 in CLEAR, SHIFT and FINISH, and 0 in IDLE.
REQ-019 config_nreset SHALL be 1 in IDLE, SHIFT and FINISH.
REQ-020 The bit counter SHALL be $clog2(CHAIN_LENGTH+1) bits wide and SHALL be cleared on entry to CLEAR.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 nreset=0 SHALL asynchronously force IDLE, clear the counters and buffers, and set: config_nreset=0, config_enable=0, config_data=0, word_ready=0, rb_valid=0, rb_data=0, busy=0, done=0.
REQ-023 config_nreset SHALL return to 1 on the first clock edge after nreset deasserts.
REQ-024 Reset asserted mid-load SHALL abort the load with no done pulse; the next start SHALL re-run CLEAR.

Verification
REQ-025 With CHAIN_LENGTH=16, start, then words 0xA5, 0x3C presented continuously -> 4 CLEAR cycles, then 16 consecutive enables with config_data 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, then done once, then busy=0.
REQ-026 Same load with word_valid dropped for 3 cycles between the two words -> config_enable=0 for exactly 3 cycles, still 16 total enables, same bit order.
REQ-027 With the chain modelled as a 16-bit shift register preloaded with 0xBEEF (bit 0 nearest config_out) -> rb_valid twice, rb_data 0xEF then 0xBE; the chain ends holding the new data 0x3CA5.
REQ-028 With CHAIN_LENGTH=12, words 0xFF, 0xFF, and the chain preloaded with 0xFFF -> 12 enables, 4 high bits of the second word discarded, rb 0xFF then 0x0F in FINISH together with done.
REQ-029 Start pulsed during SHIFT -> no effect; nreset pulsed after the 5th shift -> outputs at reset values immediately, no done, and a fresh start reloads from bit 0.
